// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } grant_t;

    localparam logic ADTP_WORD = 1'b0;
    localparam logic ADTP_BYTE = 1'b1;

    localparam logic [31:0] DEFAULT_MEM_TOP = 32'h0001FFFF;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter: counts consecutive denied cycles of the low-priority
// port and flags when it has waited LIMIT cycles.
module arb_age_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // Clear dominates increment; the count sticks at LIMIT until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 has fixed priority, port 1 is forced
// through after waiting STARVE_LIMIT cycles. One registered response per accept.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP = ADDRESS_WIDTH'(DEFAULT_MEM_TOP)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    input  logic                     p0_we,
    input  logic                     p0_byte,
    output logic                     p0_rvalid,
    output logic [DATA_WIDTH-1:0]    p0_rdata,
    output logic                     p0_err,

    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    input  logic                     p1_we,
    input  logic                     p1_byte,
    output logic                     p1_rvalid,
    output logic [DATA_WIDTH-1:0]    p1_rdata,
    output logic                     p1_err,

    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    output logic                     mem_adtp,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    grant_t                   grant;
    logic                     p1_expired;
    logic                     age_inc;
    logic                     age_clr;

    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     sel_we;
    logic                     sel_byte;
    logic                     sel_in_range;
    logic [DATA_WIDTH-1:0]    rsp_rdata;

    logic                     p0_rvalid_q;
    logic                     p0_err_q;
    logic [DATA_WIDTH-1:0]    p0_rdata_q;
    logic                     p1_rvalid_q;
    logic                     p1_err_q;
    logic [DATA_WIDTH-1:0]    p1_rdata_q;

    arb_age_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .inc     (age_inc),
        .clr     (age_clr),
        .expired (p1_expired)
    );

    // Pick the winner: starving port 1 first, then port 0, then port 1.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (p1_expired && p1_valid) begin
                grant = GNT_P1;
            end else if (p0_valid) begin
                grant = GNT_P0;
            end else if (p1_valid) begin
                grant = GNT_P1;
            end
        end
    end

    assign p0_ready = (grant == GNT_P0);
    assign p1_ready = (grant == GNT_P1);

    assign age_inc = p1_valid && !p1_ready;
    assign age_clr = !p1_valid || p1_ready;

    // Route the granted request onto the shared memory; idle bus is all zeros.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_byte  = ADTP_WORD;
        case (grant)
            GNT_P0: begin
                sel_addr  = p0_addr;
                sel_wdata = p0_wdata;
                sel_we    = p0_we;
                sel_byte  = p0_byte;
            end
            GNT_P1: begin
                sel_addr  = p1_addr;
                sel_wdata = p1_wdata;
                sel_we    = p1_we;
                sel_byte  = p1_byte;
            end
            default: begin
                sel_addr  = '0;
            end
        endcase
    end

    // A word touches addr..addr+3, so its last legal start is three below the top.
    assign sel_in_range = sel_byte ? (sel_addr <= MEM_TOP)
                                   : (sel_addr <= (MEM_TOP - ADDRESS_WIDTH'(3)));

    assign mem_a    = sel_addr;
    assign mem_wd   = sel_wdata;
    assign mem_adtp = sel_byte ? ADTP_BYTE : ADTP_WORD;
    assign mem_we   = sel_we && sel_in_range;

    assign rsp_rdata = (!sel_we && sel_in_range) ? mem_rd : '0;

    // Capture the response of this cycle's access for presentation next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= (grant == GNT_P0);
            p0_err_q    <= (grant == GNT_P0) && !sel_in_range;
            p0_rdata_q  <= (grant == GNT_P0) ? rsp_rdata : '0;
            p1_rvalid_q <= (grant == GNT_P1);
            p1_err_q    <= (grant == GNT_P1) && !sel_in_range;
            p1_rdata_q  <= (grant == GNT_P1) ? rsp_rdata : '0;
        end
    end

    // A response due in a reset cycle is dropped rather than presented.
    assign p0_rvalid = p0_rvalid_q && !rst;
    assign p0_err    = p0_err_q && !rst;
    assign p0_rdata  = rst ? '0 : p0_rdata_q;
    assign p1_rvalid = p1_rvalid_q && !rst;
    assign p1_err    = p1_err_q && !rst;
    assign p1_rdata  = rst ? '0 : p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array memory model sits behind the
// DUT, a reference model predicts grants and responses, a monitor checks them.
module tb_dmem_arbiter;

    localparam int          LIM = 4;
    localparam logic [31:0] TOP = 32'h0001FFFF;
    localparam int          MSZ = 32'h20008;

    logic        clk;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we, p0_byte, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_byte, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, mem_adtp;

    typedef struct {
        bit          valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        bit          byt;
    } req_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          p1_denied = 0;
    bit          mon_en = 0;
    logic [7:0]  env_mem [MSZ];
    logic [7:0]  ref_mem [MSZ];

    dmem_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (LIM),
        .MEM_TOP       (TOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_we     (p0_we),
        .p0_byte   (p0_byte),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_we     (p1_we),
        .p1_byte   (p1_byte),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_adtp  (mem_adtp),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: combinational read, write at the clock edge.
    always_comb begin
        logic [17:0] ix;
        ix     = mem_a[17:0];
        mem_rd = '0;
        if (mem_a < 32'(MSZ - 3)) begin
            if (mem_adtp)
                mem_rd = {24'h0, env_mem[ix]};
            else
                mem_rd = {env_mem[ix + 18'd3], env_mem[ix + 18'd2],
                          env_mem[ix + 18'd1], env_mem[ix]};
        end
    end

    always @(posedge clk) begin
        logic [17:0] wx;
        wx = mem_a[17:0];
        if (mem_we && (mem_a < 32'(MSZ - 3))) begin
            env_mem[wx] = mem_wd[7:0];
            if (!mem_adtp) begin
                env_mem[wx + 18'd1] = mem_wd[15:8];
                env_mem[wx + 18'd2] = mem_wd[23:16];
                env_mem[wx + 18'd3] = mem_wd[31:24];
            end
        end
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
        end
    endtask

    function automatic req_t mk(input bit v, input logic [31:0] a, input logic [31:0] d,
                                input bit we, input bit byt);
        req_t r;
        r.valid = v;
        r.addr  = a;
        r.wdata = d;
        r.we    = we;
        r.byt   = byt;
        return r;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a, input bit byt);
        int i;
        i = int'(a);
        if (byt) return {24'h0, ref_mem[i]};
        return {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]};
    endfunction

    // Reference model for one cycle: predict grant, check bus, queue response.
    task automatic checkOutput(input bit r, input req_t a, input req_t b, output int g);
        req_t        q;
        bit          inr;
        logic [31:0] rd;
        if (r)                                 g = 0;
        else if (p1_denied == LIM && b.valid)  g = 2;
        else if (a.valid)                      g = 1;
        else if (b.valid)                      g = 2;
        else                                   g = 0;

        compare("p0_ready", 32'(p0_ready), 32'(g == 1));
        compare("p1_ready", 32'(p1_ready), 32'(g == 2));

        if (r) begin
            while (exp_q.size() > 0 && exp_q[$].due == cyc) void'(exp_q.pop_back());
        end

        if (g != 0) begin
            q   = (g == 1) ? a : b;
            inr = q.byt ? (q.addr <= TOP) : (q.addr <= TOP - 32'd3);
            compare("mem_a", mem_a, q.addr);
            compare("mem_adtp", 32'(mem_adtp), 32'(q.byt));
            compare("mem_we", 32'(mem_we), 32'(q.we && inr));
            compare("mem_wd", mem_wd, q.wdata);
            rd = (!q.we && inr) ? refRead(q.addr, q.byt) : 32'h0;
            exp_q.push_back('{due: cyc + 1, port: g - 1, rdata: rd, err: !inr});
            if (q.we && inr) begin
                ref_mem[int'(q.addr)] = q.wdata[7:0];
                if (!q.byt) begin
                    ref_mem[int'(q.addr) + 1] = q.wdata[15:8];
                    ref_mem[int'(q.addr) + 2] = q.wdata[23:16];
                    ref_mem[int'(q.addr) + 3] = q.wdata[31:24];
                end
            end
        end else begin
            compare("idle_mem_we", 32'(mem_we), 32'h0);
            compare("idle_mem_a", mem_a, 32'h0);
        end

        if (r || !b.valid || g == 2) p1_denied = 0;
        else if (p1_denied < LIM)    p1_denied++;
    endtask

    task automatic applyStimulus(input bit r, input req_t a, input req_t b, output int g);
        @(posedge clk);
        #1;
        rst      = r;
        p0_valid = a.valid; p0_addr = a.addr; p0_wdata = a.wdata; p0_we = a.we; p0_byte = a.byt;
        p1_valid = b.valid; p1_addr = b.addr; p1_wdata = b.wdata; p1_we = b.we; p1_byte = b.byt;
        #2;
        checkOutput(r, a, b, g);
    endtask

    function automatic req_t randReq();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = 32'h0001FFF8 + 32'($urandom_range(0, 11));
        else                           a = 32'h00010000 + 32'($urandom_range(0, 15));
        return mk($urandom_range(0, 3) != 0, a, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0);
    endfunction

    // Monitor: every response must appear exactly in the cycle it is due.
    always @(negedge clk) begin
        if (mon_en) begin
            rsp_t e;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                compare("lost_response", 32'(e.due), 32'(cyc));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.port == 0) begin
                    compare("p0_rvalid", 32'(p0_rvalid), 32'h1);
                    compare("p1_rvalid_quiet", 32'(p1_rvalid), 32'h0);
                    compare("p0_rdata", p0_rdata, e.rdata);
                    compare("p0_err", 32'(p0_err), 32'(e.err));
                end else begin
                    compare("p1_rvalid", 32'(p1_rvalid), 32'h1);
                    compare("p0_rvalid_quiet", 32'(p0_rvalid), 32'h0);
                    compare("p1_rdata", p1_rdata, e.rdata);
                    compare("p1_err", 32'(p1_err), 32'(e.err));
                end
            end else begin
                compare("no_p0_rvalid", 32'(p0_rvalid), 32'h0);
                compare("no_p1_rvalid", 32'(p1_rvalid), 32'h0);
                if (rst) begin
                    compare("rst_rdata", p0_rdata | p1_rdata, 32'h0);
                    compare("rst_err", 32'(p0_err | p1_err), 32'h0);
                end
            end
        end
    end

    // Directed scenarios, then a randomized run against the reference model.
    initial begin
        req_t idle, a, b;
        int   g;
        logic [7:0] v;

        for (int i = 0; i < MSZ; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        idle = mk(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        p0_valid = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0; p0_byte = 0;
        p1_valid = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0; p1_byte = 0;

        applyStimulus(1, mk(1, 32'h10000, 32'h1, 1, 0), mk(1, 32'h10004, 32'h2, 1, 0), g);
        mon_en = 1;
        applyStimulus(1, mk(1, 32'h10000, 32'h1, 1, 0), mk(1, 32'h10004, 32'h2, 1, 0), g);

        $display("[TB] single-port write/read");
        applyStimulus(0, mk(1, 32'h10000, 32'hDEADBEEF, 1, 0), idle, g);
        applyStimulus(0, mk(1, 32'h10000, 32'h0, 0, 0), idle, g);
        applyStimulus(0, idle, idle, g);

        $display("[TB] byte merge across ports");
        applyStimulus(0, mk(1, 32'h10000, 32'h11223344, 1, 0), idle, g);
        applyStimulus(0, idle, mk(1, 32'h10003, 32'h000000AB, 1, 1), g);
        applyStimulus(0, mk(1, 32'h10000, 32'h0, 0, 0), idle, g);

        $display("[TB] range boundaries");
        applyStimulus(0, mk(1, 32'h1FFFE, 32'hCAFEF00D, 1, 0), idle, g);
        applyStimulus(0, mk(1, 32'h1FFFF, 32'h0, 0, 1), idle, g);
        applyStimulus(0, mk(1, 32'h20000, 32'h0, 0, 1), idle, g);
        applyStimulus(0, idle, mk(1, 32'h1FFFC, 32'h0, 0, 0), g);
        applyStimulus(0, idle, mk(1, 32'h1FFFD, 32'h0, 0, 0), g);
        applyStimulus(0, idle, idle, g);

        $display("[TB] starvation pattern");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, mk(1, 32'h10020 + 32'(4 * i), 32'(i), 1, 0),
                          mk(1, 32'h10040, 32'h0, 0, 0), g);
            compare("starve_p1_ready", 32'(p1_ready), 32'(i % 5 == 4));
            compare("starve_p0_ready", 32'(p0_ready), 32'(i % 5 != 4));
        end
        applyStimulus(0, idle, idle, g);

        $display("[TB] reset after accept");
        applyStimulus(0, mk(1, 32'h10000, 32'h0, 0, 0), idle, g);
        applyStimulus(1, mk(1, 32'h10004, 32'h0, 0, 0), mk(1, 32'h10008, 32'h0, 0, 0), g);
        applyStimulus(1, mk(1, 32'h10004, 32'h0, 0, 0), mk(1, 32'h10008, 32'h0, 0, 0), g);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, mk(1, 32'h10004, 32'h0, 0, 0), mk(1, 32'h10008, 32'h0, 0, 0), g);
            compare("post_rst_p1_ready", 32'(p1_ready), 32'(i == 4));
        end
        applyStimulus(0, idle, idle, g);

        $display("[TB] randomized traffic");
        a = idle;
        b = idle;
        g = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(a.valid && g != 1)) a = randReq();
            if (!(b.valid && g != 2)) b = randReq();
            applyStimulus($urandom_range(0, 49) == 0, a, b, g);
        end

        applyStimulus(0, idle, idle, g);
        applyStimulus(0, idle, idle, g);
        @(posedge clk);
        #1;
        compare("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single byte-addressed data memory between the CPU load/store unit (port 0) and a secondary master such as a loader or debug/DMA engine (port 1). Each port uses a valid/ready request handshake and gets a registered response one cycle after grant. Port 0 has fixed priority, and an aging counter keeps port 1 from starving. Sits between the requesters and the data memory, driving its address, write-data, write-enable and addressing-type pins.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, number of consecutive denied cycles for port 1 before it is forced to win
- MEM_TOP, 32'h0001FFFF, highest valid byte address
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- pN_valid  in  1  request valid, N∈{0,1}
- pN_ready  out  1  request accepted this cycle (combinational grant)
- pN_addr  in  ADDRESS_WIDTH  byte address
- pN_wdata  in  DATA_WIDTH  write data
- pN_we  in  1  1 = write, 0 = read
- pN_byte  in  1  1 = byte access (low 8 bits, zero-extended on read), 0 = word, little-endian
- pN_rvalid  out  1  response valid, exactly one cycle after acceptance
- pN_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- pN_err  out  1  access was out of range and not performed
- mem_a  out  ADDRESS_WIDTH  memory address
- mem_wd  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write enable
- mem_adtp  out  1  memory addressing type (0 word, 1 byte)
- mem_rd  in  DATA_WIDTH  memory read data (combinational from mem_a/mem_adtp)

## Operation
- Arbitration each cycle, evaluated in this order:
  - force = (wait_cnt == STARVE_LIMIT) && p1_valid.
  - If force: grant port 1.
  - Else if p0_valid: grant port 0.
  - Else if p1_valid: grant port 1.
  - Else: no grant.
- Grant raises the winner's pN_ready for that cycle only. At most one ready per cycle.
- wait_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments when p1_valid && !p1_ready.
  - Clears on p1 grant or when p1_valid is low.
  - Saturates at STARVE_LIMIT.
- Granted request drives mem_a/mem_wd/mem_adtp from that port. mem_we = pN_we && in-range.
- No grant: mem_a=0, mem_wd=0, mem_we=0, mem_adtp=0.
- Range check:
  - Byte access is in range iff addr ≤ MEM_TOP.
  - Word access is in range iff addr ≤ MEM_TOP−3.
  - Out of range: write suppressed; response has err=1, rdata=0.
- Misaligned word addresses within range are legal and passed through unchanged.
- Response register captures, at the accept edge: the granted port, err, and rdata = (read && in-range) ? mem_rd : 0.
  - pN_rvalid is high for exactly one cycle following acceptance.
  - Responses cannot be back-pressured.
- Back-to-back accepts are allowed every cycle on either port.
- Write then read to the same address from either port in consecutive cycles returns the written data.
- Simultaneous valid on both ports to the same address: serialized in grant order. No merging.

## Timing
- Cycle N: pN_valid && pN_ready → memory access in cycle N. Edge N→N+1 registers the response. Cycle N+1: pN_rvalid=1.
- Latency: request to response = 1 cycle. Throughput: 1 access/cycle total.
- Port 1 worst-case wait under continuous port 0 traffic is STARVE_LIMIT cycles, then granted in cycle STARVE_LIMIT+1.
- Requesters must hold addr/wdata/we/byte stable while valid && !ready.
- Reset (rst=1 at an edge):
  - wait_cnt=0.
  - All pN_rvalid/pN_err/pN_rdata=0.
  - A response pending from the prior cycle is dropped.
  - While rst=1, both pN_ready=0 and mem_we=0, regardless of valid.
  - First grant is possible in the first cycle with rst=0.

## Structure
- Package dmem_arb_pkg:
  - typedef enum grant_t {GNT_NONE, GNT_P0, GNT_P1}
  - localparams ADTP_WORD=1'b0, ADTP_BYTE=1'b1
  - default MEM_TOP
- Sub-module arb_age_counter: saturating wait counter with inc/clr inputs and an expired output. Parameterised by LIMIT.
- Remaining logic (grant mux, range check, response register) lives inline in dmem_arbiter.

## Test plan
- Single port 0 word write of 0xDEADBEEF to 0x10000, then word read → rvalid one cycle after each accept; read rdata=0xDEADBEEF, err=0.
- Both valid every cycle, STARVE_LIMIT=4 → port 0 granted cycles 0–3, port 1 granted cycle 4, then port 0 again; repeat pattern period 5.
- Port 1 byte write of 0x000000AB to 0x10003, then port 0 word read at 0x10000 after a prior word write of 0x11223344 → rdata=0xAB223344.
- Out-of-range accesses:
  - Word write at 0x1FFFE → mem_we stays 0, err=1, rdata=0.
  - Byte read at 0x1FFFF → err=0.
  - Byte read at 0x20000 → err=1.
- Assert rst the cycle after a port 0 read accept → no rvalid is seen, wait_cnt=0, ready stays 0 during reset, and a fresh request completes normally after release.
